gemm_layer_sequencer: RTL and testbench

//  Layer-level controller sitting in front of the GEMM engine. Accepts layer descriptors
//  (conv/FC geometry plus requant params) into a small queue. Drives GEMM config, the init

---
 rtl/gemm_seq_pkg.sv | 13 +
 rtl/gemm_desc_fifo.sv | 46 ++++
 rtl/gemm_layer_sequencer.sv | 171 +++++++++++++++++
 tb/tb_gemm_layer_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_seq_pkg.sv
// gemm_seq_pkg: shared FSM state encoding and descriptor field widths for the GEMM layer sequencer
//   state_e  : IDLE/INIT/RUN/DRAIN/DONE controller states
//   desc_w() : packed descriptor width for a given geometry and beat-count width
package gemm_seq_pkg;
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_e;
    localparam int STRIDE_W = 4;
    localparam int WORD_W   = 32;
    // is_fc + 6 geometry fields + 2 strides + padding + qmult/shift/offset + beat count
    function automatic int desc_w(input int addr_w, input int beat_w);
        return 1 + 6 * addr_w + 2 * STRIDE_W + 1 + 3 * WORD_W + beat_w;
    endfunction
    localparam int DESC_W = desc_w(13, 20);
endpackage

// File: rtl/gemm_desc_fifo.sv
// gemm_desc_fifo: synchronous descriptor FIFO with full/empty flags and flush
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   flush_i           : drop all entries (wins over push/pop)
//   push_i / data_i   : write when not full
//   pop_i / data_o    : data_o is the head entry, advanced by pop when not empty
//   full_o, empty_o   : occupancy flags
module gemm_desc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic         wr_en, rd_en;
    // pointers carry one extra wrap bit so full and empty are distinguishable
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = wr_q == rd_q;
    assign data_o  = mem_q[rd_q[AW-1:0]];
    assign wr_en   = push_i && !full_o && !flush_i;
    assign rd_en   = pop_i && !empty_o && !flush_i;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/gemm_layer_sequencer.sv
// gemm_layer_sequencer: queues layer descriptors and sequences the GEMM engine one layer at a time
//   desc_*_i / desc_valid_i / desc_ready_o : descriptor push interface (valid && ready)
//   abort_i    : kill active layer and flush queue; err_clr_i clears sticky errors
//   requant_valid_i : one requantised output beat from the GEMM
//   gemm_*_o   : registered config, init pulse and conv/fc enables of the active layer
//   busy_o, layer_done_o, layer_count_o, timeout_err_o, overrun_err_o : status
module gemm_layer_sequencer
    import gemm_seq_pkg::*;
#(
    parameter int ADDR_WIDTH     = 13,
    parameter int BEAT_WIDTH     = 20,
    parameter int DESC_DEPTH     = 2,
    parameter int INIT_CYCLES    = 1,
    parameter int DRAIN_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  desc_valid_i,
    output logic                  desc_ready_o,
    input  logic                  desc_is_fc_i,
    input  logic [ADDR_WIDTH-1:0] desc_img_row_i,
    input  logic [ADDR_WIDTH-1:0] desc_img_col_i,
    input  logic [ADDR_WIDTH-1:0] desc_ker_row_i,
    input  logic [ADDR_WIDTH-1:0] desc_ker_col_i,
    input  logic [ADDR_WIDTH-1:0] desc_in_ch_i,
    input  logic [ADDR_WIDTH-1:0] desc_out_ch_i,
    input  logic [3:0]            desc_stride_h_i,
    input  logic [3:0]            desc_stride_w_i,
    input  logic                  desc_padding_i,
    input  logic [31:0]           desc_qmult_i,
    input  logic [31:0]           desc_shift_i,
    input  logic [31:0]           desc_out_offset_i,
    input  logic [BEAT_WIDTH-1:0] desc_out_beats_i,
    input  logic                  abort_i,
    input  logic                  err_clr_i,
    input  logic                  requant_valid_i,
    output logic                  gemm_init_o,
    output logic                  gemm_conv_en_o,
    output logic                  gemm_fc_en_o,
    output logic [ADDR_WIDTH-1:0] gemm_img_row_o,
    output logic [ADDR_WIDTH-1:0] gemm_img_col_o,
    output logic [ADDR_WIDTH-1:0] gemm_ker_row_o,
    output logic [ADDR_WIDTH-1:0] gemm_ker_col_o,
    output logic [ADDR_WIDTH-1:0] gemm_in_ch_o,
    output logic [ADDR_WIDTH-1:0] gemm_out_ch_o,
    output logic [3:0]            gemm_stride_h_o,
    output logic [3:0]            gemm_stride_w_o,
    output logic                  gemm_padding_o,
    output logic [31:0]           gemm_qmult_o,
    output logic [31:0]           gemm_shift_o,
    output logic [31:0]           gemm_out_offset_o,
    output logic                  busy_o,
    output logic                  layer_done_o,
    output logic [15:0]           layer_count_o,
    output logic                  timeout_err_o,
    output logic                  overrun_err_o
);
    localparam int DW = desc_w(ADDR_WIDTH, BEAT_WIDTH);
    localparam int CW = $clog2((INIT_CYCLES > DRAIN_CYCLES ? INIT_CYCLES : DRAIN_CYCLES) + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);
    state_e                state_q;
    logic [DW-1:0]         cfg_q, head;
    logic [CW-1:0]         cnt_q;
    logic [BEAT_WIDTH-1:0] beat_cnt_q, cfg_beats;
    logic [WW-1:0]         wdog_q;
    logic                  cfg_fc, rdy_q, fifo_full, fifo_empty, pop;
    // rdy_q keeps desc_ready low until the first clock after reset release
    assign desc_ready_o = rdy_q && !fifo_full && !abort_i;
    assign pop          = state_q == S_IDLE && !fifo_empty && !abort_i;
    assign busy_o       = state_q != S_IDLE || !fifo_empty;
    assign {cfg_fc, gemm_img_row_o, gemm_img_col_o, gemm_ker_row_o, gemm_ker_col_o, gemm_in_ch_o,
            gemm_out_ch_o, gemm_stride_h_o, gemm_stride_w_o, gemm_padding_o, gemm_qmult_o,
            gemm_shift_o, gemm_out_offset_o, cfg_beats} = cfg_q;
    gemm_desc_fifo #(.W(DW), .DEPTH(DESC_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (abort_i),
        .push_i  (desc_valid_i && desc_ready_o),
        .pop_i   (pop),
        .data_i  ({desc_is_fc_i, desc_img_row_i, desc_img_col_i, desc_ker_row_i, desc_ker_col_i,
                   desc_in_ch_i, desc_out_ch_i, desc_stride_h_i, desc_stride_w_i, desc_padding_i,
                   desc_qmult_i, desc_shift_i, desc_out_offset_i, desc_out_beats_i}),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
    // later assignments in this block override earlier ones: error sets beat err_clr,
    // and abort overrides every state transition
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            cfg_q          <= '0;
            cnt_q          <= '0;
            beat_cnt_q     <= '0;
            wdog_q         <= '0;
            rdy_q          <= 1'b0;
            gemm_init_o    <= 1'b0;
            gemm_conv_en_o <= 1'b0;
            gemm_fc_en_o   <= 1'b0;
            layer_done_o   <= 1'b0;
            layer_count_o  <= '0;
            timeout_err_o  <= 1'b0;
            overrun_err_o  <= 1'b0;
        end else begin
            rdy_q        <= 1'b1;
            layer_done_o <= 1'b0;
            if (err_clr_i) begin
                timeout_err_o <= 1'b0;
                overrun_err_o <= 1'b0;
            end
            if (requant_valid_i && state_q inside {S_IDLE, S_DRAIN, S_DONE}) overrun_err_o <= 1'b1;
            if (abort_i) begin
                state_q        <= S_IDLE;
                gemm_init_o    <= 1'b0;
                gemm_conv_en_o <= 1'b0;
                gemm_fc_en_o   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (pop) begin
                        cfg_q       <= head;
                        cnt_q       <= '0;
                        beat_cnt_q  <= '0;
                        wdog_q      <= '0;
                        gemm_init_o <= 1'b1;
                        state_q     <= S_INIT;
                    end
                    S_INIT: if (cnt_q == INIT_LAST) begin
                        cnt_q       <= '0;
                        gemm_init_o <= 1'b0;
                        if (cfg_beats == '0) begin
                            state_q       <= S_DONE;
                            layer_done_o  <= 1'b1;
                            layer_count_o <= layer_count_o + 1'b1;
                        end else begin
                            state_q        <= S_RUN;
                            gemm_conv_en_o <= !cfg_fc;
                            gemm_fc_en_o   <= cfg_fc;
                        end
                    end else cnt_q <= cnt_q + 1'b1;
                    S_RUN: if (requant_valid_i) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        wdog_q     <= '0;
                        if (beat_cnt_q + 1'b1 == cfg_beats) begin
                            state_q        <= S_DRAIN;
                            gemm_conv_en_o <= 1'b0;
                            gemm_fc_en_o   <= 1'b0;
                        end
                    end else if (wdog_q == WD_LAST) begin
                        state_q        <= S_DONE;
                        timeout_err_o  <= 1'b1;
                        layer_done_o   <= 1'b1;
                        layer_count_o  <= layer_count_o + 1'b1;
                        gemm_conv_en_o <= 1'b0;
                        gemm_fc_en_o   <= 1'b0;
                    end else wdog_q <= wdog_q + 1'b1;
                    S_DRAIN: if (cnt_q == DRAIN_LAST) begin
                        state_q       <= S_DONE;
                        layer_done_o  <= 1'b1;
                        layer_count_o <= layer_count_o + 1'b1;
                    end else cnt_q <= cnt_q + 1'b1;
                    S_DONE: state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gemm_layer_sequencer.sv
// tb_gemm_layer_sequencer: randomized self-checking bench against a timeline model of each layer
module tb_gemm_layer_sequencer;
    localparam int AW = 13, BW = 20, INIT = 1, DRAIN = 8, TMO = 64;
    typedef struct packed {
        logic fc;
        logic [AW-1:0] ir, ic, kr, kc, ich, och;
        logic [3:0] sh, sw;
        logic pad;
        logic [31:0] qm, shf, off;
        logic [BW-1:0] beats;
    } desc_t;
    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic desc_valid_i = 1'b0, desc_is_fc_i = 1'b0, desc_padding_i = 1'b0;
    logic abort_i = 1'b0, err_clr_i = 1'b0, requant_valid_i = 1'b0;
    logic [AW-1:0] desc_img_row_i = '0, desc_img_col_i = '0, desc_ker_row_i = '0;
    logic [AW-1:0] desc_ker_col_i = '0, desc_in_ch_i = '0, desc_out_ch_i = '0;
    logic [3:0] desc_stride_h_i = '0, desc_stride_w_i = '0;
    logic [31:0] desc_qmult_i = '0, desc_shift_i = '0, desc_out_offset_i = '0;
    logic [BW-1:0] desc_out_beats_i = '0;
    logic desc_ready_o, gemm_init_o, gemm_conv_en_o, gemm_fc_en_o, gemm_padding_o;
    logic busy_o, layer_done_o, timeout_err_o, overrun_err_o;
    logic [AW-1:0] gemm_img_row_o, gemm_img_col_o, gemm_ker_row_o, gemm_ker_col_o, gemm_in_ch_o, gemm_out_ch_o;
    logic [3:0] gemm_stride_h_o, gemm_stride_w_o;
    logic [31:0] gemm_qmult_o, gemm_shift_o, gemm_out_offset_o;
    logic [15:0] layer_count_o;
    int n_chk = 0, n_pass = 0, exp_count = 0;
    bit exp_tmo = 0, exp_ovr = 0;
    desc_t model_q[$];

    always #5 clk_i = ~clk_i;

    gemm_layer_sequencer #(.ADDR_WIDTH(AW), .BEAT_WIDTH(BW), .DESC_DEPTH(2), .INIT_CYCLES(INIT),
                           .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_is_fc_i(desc_is_fc_i), .desc_img_row_i(desc_img_row_i), .desc_img_col_i(desc_img_col_i),
        .desc_ker_row_i(desc_ker_row_i), .desc_ker_col_i(desc_ker_col_i), .desc_in_ch_i(desc_in_ch_i),
        .desc_out_ch_i(desc_out_ch_i), .desc_stride_h_i(desc_stride_h_i), .desc_stride_w_i(desc_stride_w_i),
        .desc_padding_i(desc_padding_i), .desc_qmult_i(desc_qmult_i), .desc_shift_i(desc_shift_i),
        .desc_out_offset_i(desc_out_offset_i), .desc_out_beats_i(desc_out_beats_i), .abort_i(abort_i),
        .err_clr_i(err_clr_i), .requant_valid_i(requant_valid_i), .gemm_init_o(gemm_init_o),
        .gemm_conv_en_o(gemm_conv_en_o), .gemm_fc_en_o(gemm_fc_en_o), .gemm_img_row_o(gemm_img_row_o),
        .gemm_img_col_o(gemm_img_col_o), .gemm_ker_row_o(gemm_ker_row_o), .gemm_ker_col_o(gemm_ker_col_o),
        .gemm_in_ch_o(gemm_in_ch_o), .gemm_out_ch_o(gemm_out_ch_o), .gemm_stride_h_o(gemm_stride_h_o),
        .gemm_stride_w_o(gemm_stride_w_o), .gemm_padding_o(gemm_padding_o), .gemm_qmult_o(gemm_qmult_o),
        .gemm_shift_o(gemm_shift_o), .gemm_out_offset_o(gemm_out_offset_o), .busy_o(busy_o),
        .layer_done_o(layer_done_o), .layer_count_o(layer_count_o), .timeout_err_o(timeout_err_o),
        .overrun_err_o(overrun_err_o)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [255:0] cfg_of(input desc_t d);
        return 256'({d.ir, d.ic, d.kr, d.kc, d.ich, d.och, d.sh, d.sw, d.pad, d.qm, d.shf, d.off});
    endfunction

    function automatic logic [255:0] gemm_cfg();
        return 256'({gemm_img_row_o, gemm_img_col_o, gemm_ker_row_o, gemm_ker_col_o, gemm_in_ch_o,
                     gemm_out_ch_o, gemm_stride_h_o, gemm_stride_w_o, gemm_padding_o, gemm_qmult_o,
                     gemm_shift_o, gemm_out_offset_o});
    endfunction

    function automatic logic [255:0] all_outs();
        return gemm_cfg() | 256'({gemm_init_o, gemm_conv_en_o, gemm_fc_en_o, desc_ready_o, busy_o,
                                  layer_done_o, layer_count_o, timeout_err_o, overrun_err_o});
    endfunction

    function automatic desc_t rand_desc(input int beats, input bit fc);
        desc_t d;
        d.fc = fc;
        d.ir = AW'($urandom); d.ic = AW'($urandom); d.kr = AW'($urandom);
        d.kc = AW'($urandom); d.ich = AW'($urandom); d.och = AW'($urandom);
        d.sh = 4'($urandom); d.sw = 4'($urandom); d.pad = 1'($urandom);
        d.qm = $urandom; d.shf = $urandom; d.off = $urandom;
        d.beats = BW'(beats);
        return d;
    endfunction

    task automatic push(input desc_t d);
        int n = 0;
        {desc_is_fc_i, desc_img_row_i, desc_img_col_i, desc_ker_row_i, desc_ker_col_i, desc_in_ch_i,
         desc_out_ch_i, desc_stride_h_i, desc_stride_w_i, desc_padding_i, desc_qmult_i, desc_shift_i,
         desc_out_offset_i, desc_out_beats_i} = d;
        desc_valid_i = 1'b1;
        @(negedge clk_i);
        while (!desc_ready_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        check("push_ready", 256'(desc_ready_o), 256'(1));
        if (desc_ready_o) model_q.push_back(d);
        tick();
        desc_valid_i = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!gemm_init_o && n < 300) begin
            tick();
            n++;
        end
        check("init_seen", 256'(gemm_init_o), 256'(1));
    endtask

    // entered in the first cycle gemm_init is high; returns one cycle after the layer_done pulse
    task automatic run_active(input int gmin, input int gmax, input int ovr_at, input bit tmo);
        desc_t d;
        bit ok = 1;
        logic [1:0] en;
        d = model_q.pop_front();
        en = {!d.fc, d.fc};
        check("cfg", gemm_cfg(), cfg_of(d));
        check("en_in_init", 256'({gemm_conv_en_o, gemm_fc_en_o}), 256'(0));
        for (int i = 1; i < INIT; i++) begin
            tick();
            ok &= gemm_init_o;
        end
        tick();
        check("init_drop", 256'({gemm_init_o, ok}), 256'(1));
        if (d.beats == '0) begin
            exp_count++;
            check("zero_en", 256'({gemm_conv_en_o, gemm_fc_en_o}), 256'(0));
            check("zero_done", 256'(layer_done_o), 256'(1));
            check("zero_count", 256'(layer_count_o), 256'(exp_count[15:0]));
        end else if (tmo) begin
            check("run_en", 256'({gemm_conv_en_o, gemm_fc_en_o}), 256'(en));
            for (int i = 1; i < TMO; i++) begin
                tick();
                ok &= ({gemm_conv_en_o, gemm_fc_en_o} == en) && !layer_done_o && !timeout_err_o;
            end
            check("tmo_hold", 256'(ok), 256'(1));
            tick();
            exp_count++;
            exp_tmo = 1;
            check("tmo_done", 256'({layer_done_o, gemm_conv_en_o, gemm_fc_en_o}), 256'(4));
            check("tmo_count", 256'(layer_count_o), 256'(exp_count[15:0]));
        end else begin
            check("run_en", 256'({gemm_conv_en_o, gemm_fc_en_o}), 256'(en));
            for (int b = 0; b < int'(d.beats); b++) begin
                repeat ($urandom_range(gmax, gmin)) begin
                    tick();
                    ok &= {gemm_conv_en_o, gemm_fc_en_o} == en;
                end
                requant_valid_i = 1'b1;
                tick();
                requant_valid_i = 1'b0;
                if (b < int'(d.beats) - 1) ok &= {gemm_conv_en_o, gemm_fc_en_o} == en;
            end
            check("run_hold", 256'(ok), 256'(1));
            check("en_drop", 256'({gemm_conv_en_o, gemm_fc_en_o}), 256'(0));
            for (int k = 1; k < DRAIN; k++) begin
                if (k == ovr_at) requant_valid_i = 1'b1;
                tick();
                requant_valid_i = 1'b0;
                ok &= !layer_done_o && !gemm_conv_en_o && !gemm_fc_en_o && !gemm_init_o;
            end
            check("drain_quiet", 256'(ok), 256'(1));
            tick();
            exp_count++;
            check("done_pulse", 256'(layer_done_o), 256'(1));
            check("done_count", 256'(layer_count_o), 256'(exp_count[15:0]));
        end
        check("err_flags", 256'({timeout_err_o, overrun_err_o}), 256'({exp_tmo, exp_ovr}));
        check("cfg_stable", gemm_cfg(), cfg_of(d));
        tick();
        check("done_once", 256'(layer_done_o), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit ok;
        #12;
        check("rst_outs", all_outs(), 256'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check("ready_after_rst", 256'({desc_ready_o, busy_o, layer_count_o}), 256'(1 << 17));

        // single conv layer, 4 beats spaced 3 cycles apart
        push(rand_desc(4, 0));
        check("idle_busy", 256'(busy_o), 256'(1));
        wait_init(n);
        check("latency", 256'(n), 256'(1));
        run_active(2, 2, -1, 0);

        // back-to-back descriptors with backpressure once the queue fills
        fork
            begin
                for (int i = 0; i < 3; i++) push(rand_desc($urandom_range(3, 1), 1'($urandom)));
                check("ready_full", 256'(desc_ready_o), 256'(0));
                push(rand_desc($urandom_range(3, 1), 1'($urandom)));
            end
            begin
                int m;
                for (int l = 0; l < 4; l++) begin
                    wait_init(m);
                    check("queue_lat", 256'(m), 256'(l == 0 ? 2 : 1));
                    run_active(0, 3, -1, 0);
                end
            end
        join

        // FC watchdog timeout, then error clearing
        push(rand_desc(2, 1));
        wait_init(n);
        run_active(0, 0, -1, 1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        exp_tmo = 0;
        check("tmo_clr", 256'(timeout_err_o), 256'(0));
        requant_valid_i = 1'b1;
        err_clr_i = 1'b1;
        tick();
        requant_valid_i = 1'b0;
        err_clr_i = 1'b0;
        check("idle_beat_set_wins", 256'(overrun_err_o), 256'(1));
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("ovr_clr", 256'(overrun_err_o), 256'(0));

        // abort mid-RUN with one descriptor still queued
        push(rand_desc(5, 0));
        push(rand_desc(2, 1));
        n = 0;
        while (!gemm_conv_en_o && n < 10) begin
            tick();
            n++;
        end
        check("abort_in_run", 256'(gemm_conv_en_o), 256'(1));
        requant_valid_i = 1'b1;
        tick();
        requant_valid_i = 1'b0;
        abort_i = 1'b1;
        @(negedge clk_i);
        check("abort_ready", 256'(desc_ready_o), 256'(0));
        tick();
        abort_i = 1'b0;
        model_q.delete();
        check("abort_outs", 256'({gemm_init_o, gemm_conv_en_o, gemm_fc_en_o, busy_o, layer_done_o}), 256'(0));
        check("abort_count", 256'(layer_count_o), 256'(exp_count[15:0]));
        ok = 1;
        repeat (6) begin
            tick();
            ok &= !gemm_init_o && !layer_done_o && !busy_o;
        end
        check("abort_flushed", 256'(ok), 256'(1));

        // zero-beat layer goes straight from INIT to DONE
        push(rand_desc(0, 1));
        wait_init(n);
        check("zero_latency", 256'(n), 256'(1));
        run_active(0, 0, -1, 0);

        // randomized layers
        for (int r = 0; r < 6; r++) begin
            push(rand_desc($urandom_range(5, 0), 1'($urandom)));
            wait_init(n);
            check("rand_latency", 256'(n), 256'(1));
            run_active(0, 4, -1, 0);
        end

        // extra beat during DRAIN sets a sticky overrun
        push(rand_desc(2, 0));
        wait_init(n);
        exp_ovr = 1;
        run_active(0, 2, 3, 0);
        repeat (3) tick();
        check("ovr_sticky", 256'(overrun_err_o), 256'(1));

        // asynchronous reset in the middle of RUN
        push(rand_desc(3, 1));
        wait_init(n);
        repeat (2) tick();
        check("pre_rst_run", 256'(gemm_fc_en_o), 256'(1));
        #2 rst_ni = 1'b0;
        #1 check("async_rst_outs", all_outs(), 256'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_q.delete();
        exp_count = 0;
        exp_ovr = 0;
        tick();
        check("rst_release", 256'({desc_ready_o, busy_o, layer_count_o, overrun_err_o}), 256'(1 << 18));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
